rr_grant_arbiter16: RTL

//  - Registered round-robin arbiter for 16 requesters.
//  - Drives the one-hot select of the downstream 16:1 one-hot mux that

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_grant_arbiter16_pick.sv | 36 +++
 rtl/rr_grant_arbiter16.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// +-------------------------------------------------------------------+
// | arb_pkg : shared types, sizes and helpers for rr_grant_arbiter16  |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;
  localparam int HOLD_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Assumes a one-hot or all-zero input; all-zero maps to index 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_arbiter16_pick.sv
// +-------------------------------------------------------------------+
// | rr_pick16 : combinational round-robin pick (first set from ptr)   |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`default_nettype none

module rr_pick16
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     ffs_idx;

  always_comb begin
    req_dbl = {req, req};
    // req_rot[i] = req[(ptr + i) mod 16]
    req_rot = req_dbl[{1'b0, ptr} +: NUM_REQ];
    ffs_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) ffs_idx = IDX_W'(i);
    end
    any      = |req;
    pick_idx = any ? IDX_W'(ffs_idx + ptr) : '0;
    pick_oh  = any ? (NUM_REQ'(1) << pick_idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/rr_grant_arbiter16.sv
// +-------------------------------------------------------------------+
// | rr_grant_arbiter16 : registered 16-way round-robin grant arbiter  |
// | Optional owner timeout via macro ARB_TIMEOUT_EN. Revision 1.0     |
// +-------------------------------------------------------------------+
`default_nettype none

module rr_grant_arbiter16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               preempt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_max_hold_check
    $error("MAX_HOLD out of range 2..65535");
  end

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;

  logic [NUM_REQ-1:0] pick_req;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               owner_release;
  logic [IDX_W-1:0]   next_ptr;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;
`endif

  // While granted, the owner is masked out so a timeout never re-picks it.
  assign next_ptr      = IDX_W'(gnt_idx_q + IDX_W'(1));
  assign pick_req      = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign pick_ptr      = (state_q == GRANT) ? next_ptr : ptr_q;
  assign owner_release = (state_q == GRANT) && ((req & gnt_q) == '0);

  rr_pick16 u_pick (
    .req      (pick_req),
    .ptr      (pick_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (owner_release) begin
          ptr_d = next_ptr;
          if (pick_any) begin
            gnt_d = pick_oh;
`ifdef ARB_TIMEOUT_EN
            hold_d = '0;
`endif
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST && pick_any) begin
          ptr_d     = next_ptr;
          gnt_d     = pick_oh;
          hold_d    = '0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    gnt_idx_d   = onehot_to_idx(gnt_d);
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      preempt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      preempt_q   <= preempt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign preempt   = preempt_q;
`else
  assign preempt   = 1'b0;
`endif

endmodule

`default_nettype wire
